// File: rtl/key_code_gen_pkg.sv
// ---------------------------------------------------------------------------
// key_code_gen_pkg : shared constants, code type and code-step helper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package key_code_gen_pkg;

  localparam int unsigned CNT_MAX_DEFAULT = 1_000_000;
  localparam logic        KEY_IDLE        = 1'b1;
  localparam int          CODE_W          = 3;

  typedef logic [CODE_W-1:0] code_t;

  // Opposing presses in the same cycle cancel; the natural overflow of the
  // 3-bit add/subtract provides the 7->0 and 0->7 wrap.
  function automatic code_t next_code(input code_t code, input logic up, input logic down);
    case ({up, down})
      2'b10:   return code + code_t'(1);
      2'b01:   return code - code_t'(1);
      default: return code;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_code_gen_filter.sv
// ---------------------------------------------------------------------------
// key_code_gen_filter : 2-FF synchronizer, saturating debounce, press pulse
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_code_gen_filter
  import key_code_gen_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic press
);

  localparam int            CW       = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] CNT_TOP  = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_FIRE = CW'(CNT_MAX - 2);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Counter saturates at CNT_TOP so a held key yields a single pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= KEY_IDLE;
      s2    <= KEY_IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1 <= key_in;
      s2 <= s1;
      if (s2 == KEY_IDLE)
        cnt <= '0;
      else if (cnt < CNT_TOP)
        cnt <= cnt + CW'(1);
      press <= (s2 != KEY_IDLE) && (cnt == CNT_FIRE);
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_code_gen.sv
// ---------------------------------------------------------------------------
// key_code_gen : debounced up/down keys step a wrapping 3-bit decoder code
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_code_gen
  import key_code_gen_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_up_in,
  input  logic key_down_in,
  output logic code_val1,
  output logic code_val2,
  output logic code_val3,
  output logic code_flag
);

  logic  press_up;
  logic  press_down;
  code_t code;

  key_code_gen_filter #(.CNT_MAX(CNT_MAX)) u_filter_up (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .key_in (key_up_in),
    .press  (press_up)
  );

  key_code_gen_filter #(.CNT_MAX(CNT_MAX)) u_filter_down (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .key_in (key_down_in),
    .press  (press_down)
  );

  // Flag is registered alongside the code so both appear in the same cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      code      <= '0;
      code_flag <= 1'b0;
    end else begin
      code      <= next_code(code, press_up, press_down);
      code_flag <= press_up ^ press_down;
    end
  end

  assign code_val1 = code[2];
  assign code_val2 = code[1];
  assign code_val3 = code[0];

endmodule

`default_nettype wire
